msrv32_skid_pipe_reg: RTL and testbench
=======================================

# msrv32_skid_pipe_reg

Parametrised pipeline register stage for the msrv32 core, the generalised successor to the fixed decode→execute register block. It carries a DATA_W-bit payload and a CTRL_W-bit control field (register-file/CSR write enables and similar) between two stages. A valid/ready handshake with a two-entry skid buffer gives full throughput without a combinational ready path. A flush input (branch taken) kills in-flight entries and zeroes their control field. Any stage boundary in the core (IF/ID, ID/EX, EX/WB) instantiates it with its own widths.

## Interface
- DATA_W, 32: payload width (operands, PC, immediate, address); ≥1
- CTRL_W, 8: control-field width; this field is forced to zero whenever the entry is not valid
- clk_in  input  1  clock, all state updates on rising edge
- reset_in  input  1  synchronous, active-high reset
- up_valid_in  input  1  upstream presents an entry
- up_ready_out  output  1  stage can accept; driven from state register only
- up_data_in  input  DATA_W  upstream payload
- up_ctrl_in  input  CTRL_W  upstream control field
- flush_in  input  1  branch_taken / kill; discards all held entries
- down_valid_out  output  1  output register holds a valid entry
- down_ready_in  input  1  downstream accepts
- down_data_out  output  DATA_W  registered payload
- down_ctrl_out  output  CTRL_W  registered control field; 0 when down_valid_out=0
- occupancy_out  output  2  entries held: 0, 1 or 2

## Operation
- accept = up_valid_in & up_ready_out; deliver = down_valid_out & down_ready_in.
- States: EMPTY (occ 0), BUSY (output reg valid, occ 1), FULL (output + skid valid, occ 2). up_ready_out = (state != FULL). down_valid_out = (state != EMPTY).
- EMPTY: accept → BUSY, out ← in. No accept → stay.
- BUSY: accept & deliver → BUSY, out ← in. Accept & !deliver → FULL, skid ← in. !accept & deliver → EMPTY, out ctrl ← 0. Neither → stay.
- FULL: deliver → BUSY, out ← skid, skid ctrl ← 0. No deliver → stay. Accept is impossible because ready is low.
- flush_in = 1 has priority over every transition except reset. Next state is EMPTY. Out ctrl and skid ctrl ← 0. Any same-cycle accept is discarded (the upstream handshake still completes and the entry is dropped). Data registers hold their value.
- Ordering: strict FIFO; the skid entry is never delivered before the output entry.
- Data registers are loaded only on the transitions listed above; otherwise they hold.

## Timing
- Reset (reset_in=1 at an edge): state EMPTY. down_valid_out=0, down_data_out=0, down_ctrl_out=0, skid data/ctrl=0, occupancy_out=0. Since state is EMPTY, up_ready_out=1 in the cycle after reset.
- reset_in asserted mid-operation (BUSY/FULL) drops all entries at that edge; it has the same effect as flush plus zeroing of the data registers.
- Latency: an entry accepted at edge N appears on down_*_out after edge N, when state is EMPTY or the same-cycle deliver frees the output register.
- Throughput: 1 entry/cycle sustained while down_ready_in=1.
- up_ready_out has no combinational dependence on down_ready_in or up_valid_in. down_* outputs are pure register outputs.
- Simultaneous flush_in & down_ready_in: the current output entry counts as delivered (downstream sees it in that cycle). The state still goes EMPTY.
- flush_in while EMPTY: no effect beyond keeping ctrl zero.

## Structure
- Shared package msrv32_pipe_pkg: 2-bit state typedef (EMPTY=0, BUSY=1, FULL=2) and occupancy constants. The DATA_W/CTRL_W defaults for each stage boundary also live here.
- One natural sub-module: msrv32_pipe_entry, a DATA_W+CTRL_W register with load, ctrl-clear and sync reset. It is instantiated twice, once for the output register and once for the skid register. The FSM stays in the top module.

## Test plan
- Reset, then stream 0x11,0x22,0x33 with ctrl 0x0F and down_ready_in=1 → each appears one cycle after accept with ctrl 0x0F. up_ready_out stays 1 and occupancy_out stays 1.
- Send 0xA1,0xA2 with down_ready_in=0 → occupancy_out 1 then 2 and up_ready_out=0. Raise down_ready_in → 0xA1 then 0xA2 in order, then occupancy 0.
- From FULL (0xB1,0xB2), pulse flush_in with up_valid_in=1 and data 0xB3 → next cycle down_valid_out=0, down_ctrl_out=0, occupancy 0. 0xB3 is never delivered.
- In BUSY with 0xC1, assert flush_in & down_ready_in together → 0xC1 is observed for that cycle, then state is EMPTY.
- Assert reset_in in FULL → next cycle all outputs are 0, occupancy 0, up_ready_out=1.
- Random valid/ready/flush for 10k cycles (DATA_W=7, CTRL_W=3) → scoreboard: order preserved, no duplicates, ctrl=0 whenever valid=0.

Source files
------------

// File: rtl/msrv32_pipe_pkg.sv
// Shared types and constants for msrv32 pipeline register stages.
// Holds the stage state encoding, occupancy codes and per-boundary widths.
package msrv32_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_t;

    localparam logic [1:0] OCC_ZERO = 2'd0;
    localparam logic [1:0] OCC_ONE  = 2'd1;
    localparam logic [1:0] OCC_TWO  = 2'd2;

    // Default widths for each stage boundary in the core.
    localparam int IF_ID_DATA_W = 64;
    localparam int IF_ID_CTRL_W = 4;
    localparam int ID_EX_DATA_W = 32;
    localparam int ID_EX_CTRL_W = 8;
    localparam int EX_WB_DATA_W = 32;
    localparam int EX_WB_CTRL_W = 4;

    function automatic logic [1:0] occ_of_state(input pipe_state_t s);
        logic [1:0] occ;
        case (s)
            ST_BUSY: occ = OCC_ONE;
            ST_FULL: occ = OCC_TWO;
            default: occ = OCC_ZERO;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/msrv32_pipe_entry.sv
// One pipeline entry: payload plus control field with load, control clear and sync reset.
// Load takes priority over clear; reset zeroes both fields.
module msrv32_pipe_entry #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              load,
    input  logic              clear_ctrl,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            data <= '0;
            ctrl <= '0;
        end else if (load) begin
            data <= data_in;
            ctrl <= ctrl_in;
        end else if (clear_ctrl) begin
            ctrl <= '0;
        end
    end

endmodule

// File: rtl/msrv32_skid_pipe_reg.sv
// Valid/ready pipeline register with a two-entry skid buffer and flush.
// state | meaning:  EMPTY | nothing held;  BUSY | output reg valid;  FULL | output + skid valid
module msrv32_skid_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              up_valid_in,
    output logic              up_ready_out,
    input  logic [DATA_W-1:0] up_data_in,
    input  logic [CTRL_W-1:0] up_ctrl_in,
    input  logic              flush_in,
    output logic              down_valid_out,
    input  logic              down_ready_in,
    output logic [DATA_W-1:0] down_data_out,
    output logic [CTRL_W-1:0] down_ctrl_out,
    output logic [1:0]        occupancy_out
);
    import msrv32_pipe_pkg::*;

    pipe_state_t state, state_nxt;

    logic accept, deliver;
    logic out_load, out_clr, out_from_skid;
    logic skid_load, skid_clr;
    logic [DATA_W-1:0] skid_data, out_data_src;
    logic [CTRL_W-1:0] skid_ctrl, out_ctrl_src;

    assign up_ready_out   = (state != ST_FULL);
    assign down_valid_out = (state != ST_EMPTY);
    assign occupancy_out  = occ_of_state(state);

    assign accept  = up_valid_in & up_ready_out;
    assign deliver = down_valid_out & down_ready_in;

    always_ff @(posedge clk_in) begin
        if (reset_in) state <= ST_EMPTY;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        out_load      = 1'b0;
        out_clr       = 1'b0;
        out_from_skid = 1'b0;
        skid_load     = 1'b0;
        skid_clr      = 1'b0;
        if (flush_in) begin
            // Same-cycle accept is dropped; data registers keep their contents.
            state_nxt = ST_EMPTY;
            out_clr   = 1'b1;
            skid_clr  = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_nxt = ST_BUSY;
                        out_load  = 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (accept && deliver) begin
                        out_load = 1'b1;
                    end else if (accept) begin
                        state_nxt = ST_FULL;
                        skid_load = 1'b1;
                    end else if (deliver) begin
                        state_nxt = ST_EMPTY;
                        out_clr   = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (deliver) begin
                        state_nxt     = ST_BUSY;
                        out_load      = 1'b1;
                        out_from_skid = 1'b1;
                        skid_clr      = 1'b1;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    assign out_data_src = out_from_skid ? skid_data : up_data_in;
    assign out_ctrl_src = out_from_skid ? skid_ctrl : up_ctrl_in;

    msrv32_pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_out (
        .clk_in     (clk_in),
        .reset_in   (reset_in),
        .load       (out_load),
        .clear_ctrl (out_clr),
        .data_in    (out_data_src),
        .ctrl_in    (out_ctrl_src),
        .data       (down_data_out),
        .ctrl       (down_ctrl_out)
    );

    msrv32_pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk_in     (clk_in),
        .reset_in   (reset_in),
        .load       (skid_load),
        .clear_ctrl (skid_clr),
        .data_in    (up_data_in),
        .ctrl_in    (up_ctrl_in),
        .data       (skid_data),
        .ctrl       (skid_ctrl)
    );

endmodule

// File: tb/tb_msrv32_skid_pipe_reg.sv
// Directed bench for msrv32_skid_pipe_reg plus a queue-model random run on a 7/3-bit instance.
module tb_msrv32_skid_pipe_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        up_valid, up_ready, flush, down_valid, down_ready;
    logic [31:0] up_data, down_data;
    logic [7:0]  up_ctrl, down_ctrl;
    logic [1:0]  occ;

    logic        s_up_valid, s_up_ready, s_flush, s_down_valid, s_down_ready;
    logic [6:0]  s_up_data, s_down_data;
    logic [2:0]  s_up_ctrl, s_down_ctrl;
    logic [1:0]  s_occ;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    msrv32_skid_pipe_reg #(.DATA_W(32), .CTRL_W(8)) dut (
        .clk_in(clk), .reset_in(reset),
        .up_valid_in(up_valid), .up_ready_out(up_ready),
        .up_data_in(up_data), .up_ctrl_in(up_ctrl),
        .flush_in(flush),
        .down_valid_out(down_valid), .down_ready_in(down_ready),
        .down_data_out(down_data), .down_ctrl_out(down_ctrl),
        .occupancy_out(occ)
    );

    msrv32_skid_pipe_reg #(.DATA_W(7), .CTRL_W(3)) dut_small (
        .clk_in(clk), .reset_in(reset),
        .up_valid_in(s_up_valid), .up_ready_out(s_up_ready),
        .up_data_in(s_up_data), .up_ctrl_in(s_up_ctrl),
        .flush_in(s_flush),
        .down_valid_out(s_down_valid), .down_ready_in(s_down_ready),
        .down_data_out(s_down_data), .down_ctrl_out(s_down_ctrl),
        .occupancy_out(s_occ)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic [7:0] c);
        up_valid = 1'b1;
        up_data  = d;
        up_ctrl  = c;
        step();
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] d,
                           input logic [7:0] c, input logic [1:0] o, input logic r);
        chk({tag, "_valid"}, 32'(down_valid), 32'(v));
        chk({tag, "_data"},  down_data, d);
        chk({tag, "_ctrl"},  32'(down_ctrl), 32'(c));
        chk({tag, "_occ"},   32'(occ), 32'(o));
        chk({tag, "_ready"}, 32'(up_ready), 32'(r));
    endtask

    logic [9:0] q[$];
    logic [6:0] tag_cnt;

    initial begin
        reset = 1'b1;
        up_valid = 1'b0; up_data = '0; up_ctrl = '0; flush = 1'b0; down_ready = 1'b0;
        s_up_valid = 1'b0; s_up_data = '0; s_up_ctrl = '0; s_flush = 1'b0; s_down_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk_out("reset", 1'b0, 32'h0, 8'h0, 2'd0, 1'b1);

        // Streaming at full rate
        down_ready = 1'b1;
        push(32'h11, 8'h0F);
        chk_out("stream0", 1'b1, 32'h11, 8'h0F, 2'd1, 1'b1);
        push(32'h22, 8'h0F);
        chk_out("stream1", 1'b1, 32'h22, 8'h0F, 2'd1, 1'b1);
        push(32'h33, 8'h0F);
        chk_out("stream2", 1'b1, 32'h33, 8'h0F, 2'd1, 1'b1);
        up_valid = 1'b0;
        step();
        chk_out("drain", 1'b0, 32'h33, 8'h00, 2'd0, 1'b1);

        // Backpressure fills the skid, then drains in order
        down_ready = 1'b0;
        push(32'hA1, 8'h05);
        chk_out("bp_a1", 1'b1, 32'hA1, 8'h05, 2'd1, 1'b1);
        push(32'hA2, 8'h06);
        chk_out("bp_full", 1'b1, 32'hA1, 8'h05, 2'd2, 1'b0);
        up_valid = 1'b0;
        step();
        chk_out("bp_hold", 1'b1, 32'hA1, 8'h05, 2'd2, 1'b0);
        down_ready = 1'b1;
        step();
        chk_out("bp_a2", 1'b1, 32'hA2, 8'h06, 2'd1, 1'b1);
        step();
        chk_out("bp_empty", 1'b0, 32'hA2, 8'h00, 2'd0, 1'b1);

        // Flush from FULL with upstream presenting 0xB3
        down_ready = 1'b0;
        push(32'hB1, 8'h11);
        push(32'hB2, 8'h12);
        chk("flush_pre_occ", 32'(occ), 32'd2);
        up_data = 32'hB3; up_ctrl = 8'h13; flush = 1'b1;
        step();
        flush = 1'b0; up_valid = 1'b0;
        chk_out("flush_full", 1'b0, 32'hB1, 8'h00, 2'd0, 1'b1);
        down_ready = 1'b1;
        step();
        step();
        chk_out("flush_nob3", 1'b0, 32'hB1, 8'h00, 2'd0, 1'b1);

        // Flush while EMPTY drops a same-cycle accept
        up_valid = 1'b1; up_data = 32'hD1; up_ctrl = 8'h21; flush = 1'b1;
        step();
        flush = 1'b0; up_valid = 1'b0;
        chk_out("flush_empty", 1'b0, 32'hB1, 8'h00, 2'd0, 1'b1);

        // Flush together with deliver in BUSY
        down_ready = 1'b0;
        push(32'hC1, 8'h31);
        up_valid = 1'b0;
        flush = 1'b1; down_ready = 1'b1;
        chk("fd_seen_valid", 32'(down_valid), 32'd1);
        chk("fd_seen_data", down_data, 32'hC1);
        step();
        flush = 1'b0;
        chk_out("fd_after", 1'b0, 32'hC1, 8'h00, 2'd0, 1'b1);

        // Reset from FULL
        down_ready = 1'b0;
        push(32'hE1, 8'h41);
        push(32'hE2, 8'h42);
        up_valid = 1'b0;
        chk("rst_pre_occ", 32'(occ), 32'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_out("rst_full", 1'b0, 32'h0, 8'h00, 2'd0, 1'b1);
        // Skid was zeroed too: refill, drain, and check second entry is the new one
        push(32'hF1, 8'h51);
        push(32'hF2, 8'h52);
        up_valid = 1'b0;
        down_ready = 1'b1;
        step();
        chk_out("rst_refill", 1'b1, 32'hF2, 8'h52, 2'd1, 1'b1);
        down_ready = 1'b0;

        // Random traffic against a FIFO model on the narrow instance
        tag_cnt = 7'd0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            s_up_valid   = ($urandom_range(99) < 70);
            s_down_ready = ($urandom_range(99) < 60);
            s_flush      = ($urandom_range(99) < 3);
            s_up_data    = tag_cnt;
            s_up_ctrl    = 3'($urandom_range(7));
            chk("rnd_occ", 32'(s_occ), 32'(q.size()));
            chk("rnd_ready", 32'(s_up_ready), 32'(q.size() < 2));
            if (s_down_valid) begin
                if (q.size() == 0) chk("rnd_phantom", 32'd1, 32'd0);
                else chk("rnd_entry", 32'({s_down_ctrl, s_down_data}), 32'(q[0]));
            end else begin
                chk("rnd_ctrl_idle", 32'(s_down_ctrl), 32'd0);
            end
            if (s_down_valid && s_down_ready && q.size() > 0) void'(q.pop_front());
            if (s_flush) q.delete();
            else if (s_up_valid && s_up_ready) begin
                q.push_back({s_up_ctrl, s_up_data});
                tag_cnt = tag_cnt + 7'd1;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
